// File: rtl/binning_pkg.sv
// binning_pkg: shared types and constants for the binning controller.
// Modes, FSM states, stage-bypass encodings and a mode->bypass helper.
package binning_pkg;

  typedef enum logic [1:0] {
    BIN_BYPASS = 2'd0,
    BIN_2X2    = 2'd1,
    BIN_4X4    = 2'd2,
    BIN_RSVD   = 2'd3
  } bin_mode_t;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2,
    DRAIN  = 2'd3
  } bin_state_t;

  // bit0 bypasses stage 0, bit1 bypasses stage 1
  localparam logic [1:0] BYP_BYPASS = 2'b11;
  localparam logic [1:0] BYP_2X2    = 2'b10;
  localparam logic [1:0] BYP_4X4    = 2'b00;

  function automatic logic [1:0] mode_to_byp(
    input bin_mode_t m
  );
    logic [1:0] b;
    b = BYP_BYPASS;
    unique case (m)
      BIN_BYPASS: b = BYP_BYPASS;
      BIN_2X2:    b = BYP_2X2;
      BIN_4X4:    b = BYP_4X4;
      default:    b = BYP_BYPASS;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/binning_ctrl_edge.sv
// binning_ctrl_edge: registered edge detector for a frame strobe.
// Ports: clk, rst (sync, active low), x in; rise/fall out vs. registered x.
module binning_ctrl_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic rise,
  output logic fall
);

  logic x_d;

  always_ff @(posedge clk) begin
    if (!rst) x_d <= RST_VAL;
    else      x_d <= x;
  end

  assign rise = x & ~x_d;
  assign fall = ~x & x_d;

endmodule

// File: rtl/binning_ctrl.sv
// binning_ctrl: frame-synchronous mode controller for a 2x2 + 2x2 binning cascade.
// Ports: clk/rst (sync, active low); cfg_mode/cfg_valid/cfg_ready request;
//   vs_i/vs_mon strobes; err_clr; bypass_o, mode_o, busy_o, frame_cnt_o,
//   err_timeout_o, err_cfg_o. Define BINNING_CTRL_STATS_EN for frame/timeout stats.
module binning_ctrl
  import binning_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int FRCNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             cfg_mode,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic                   vs_i,
  input  logic                   vs_mon,
  input  logic                   err_clr,
  output logic [1:0]             bypass_o,
  output logic [1:0]             mode_o,
  output logic                   busy_o,
  output logic [FRCNT_WIDTH-1:0] frame_cnt_o,
  output logic                   err_timeout_o,
  output logic                   err_cfg_o
);

  localparam int WDW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LAST =
    WDW'(TIMEOUT_CYCLES - 1);

  bin_state_t     state;
  bin_mode_t      mode_q;
  bin_mode_t      pend_mode;
  logic           pending;
  logic           out_seen;
  logic [WDW-1:0] wd;

  logic vs_rise;
  logic vs_fall;
  logic vsm_rise;
  logic vsm_fall_unused;

  binning_ctrl_edge #(
    .RST_VAL (1'b1)
  ) u_edge_vs (
    .clk  (clk),
    .rst  (rst),
    .x    (vs_i),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  binning_ctrl_edge #(
    .RST_VAL (1'b1)
  ) u_edge_vsm (
    .clk  (clk),
    .rst  (rst),
    .x    (vs_mon),
    .rise (vsm_rise),
    .fall (vsm_fall_unused)
  );

  logic acc;
  logic rsvd;
  logic apply;
  logic drain_done;
  logic wd_exp;

  assign cfg_ready  = ~pending;
  assign acc        = cfg_valid & ~pending;
  assign rsvd       = (cfg_mode == BIN_RSVD);
  // A vs_i rise wins over an apply: the frame starts in the old mode.
  assign apply      = (state == IDLE) & pending & ~vs_rise;
  assign drain_done = out_seen & ~vs_mon;
  assign wd_exp     = (wd == WD_LAST);
  assign mode_o     = mode_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q    <= BIN_BYPASS;
      bypass_o  <= BYP_BYPASS;
      pending   <= 1'b0;
      pend_mode <= BIN_BYPASS;
      err_cfg_o <= 1'b0;
    end else begin
      if (apply) begin
        mode_q   <= pend_mode;
        bypass_o <= mode_to_byp(pend_mode);
        pending  <= 1'b0;
      end else if (acc && !rsvd) begin
        pending   <= 1'b1;
        pend_mode <= bin_mode_t'(cfg_mode);
      end
      if (acc && rsvd)  err_cfg_o <= 1'b1;
      else if (err_clr) err_cfg_o <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= SYNC;
      busy_o   <= 1'b1;
      out_seen <= 1'b0;
      wd       <= '0;
    end else begin
      unique case (state)
        SYNC: begin
          if (!vs_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        IDLE: begin
          if (vs_rise) begin
            state    <= ACTIVE;
            busy_o   <= 1'b1;
            out_seen <= 1'b0;
          end
        end
        ACTIVE: begin
          if (vsm_rise) out_seen <= 1'b1;
          if (vs_fall) begin
            state <= DRAIN;
            wd    <= '0;
          end
        end
        DRAIN: begin
          if (vsm_rise) out_seen <= 1'b1;
          if (drain_done || wd_exp) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            wd <= wd + WDW'(1);
          end
        end
        default: begin
          state  <= SYNC;
          busy_o <= 1'b1;
        end
      endcase
    end
  end

`ifdef BINNING_CTRL_STATS_EN
  logic [FRCNT_WIDTH-1:0] frame_cnt_q;
  logic                   err_to_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt_q <= '0;
      err_to_q    <= 1'b0;
    end else begin
      if (state == DRAIN && drain_done)
        frame_cnt_q <= frame_cnt_q + FRCNT_WIDTH'(1);
      if (state == DRAIN && !drain_done && wd_exp)
        err_to_q <= 1'b1;
      else if (err_clr)
        err_to_q <= 1'b0;
    end
  end

  assign frame_cnt_o   = frame_cnt_q;
  assign err_timeout_o = err_to_q;
`else
  assign frame_cnt_o   = '0;
  assign err_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_binning_ctrl.sv
// tb_binning_ctrl: directed self-checking bench for binning_ctrl.
// Covers reset/sync, handshake latency, mid-frame requests, watchdog, errors.
module tb_binning_ctrl;

`ifdef BINNING_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cfg_mode;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        vs_i;
  logic        vs_mon;
  logic        err_clr;
  logic [1:0]  bypass_o;
  logic [1:0]  mode_o;
  logic        busy_o;
  logic [15:0] frame_cnt_o;
  logic        err_timeout_o;
  logic        err_cfg_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_fc = '0;
  logic        chg;

  binning_ctrl #(
    .TIMEOUT_CYCLES (64),
    .FRCNT_WIDTH    (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_mode      (cfg_mode),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .vs_i          (vs_i),
    .vs_mon        (vs_mon),
    .err_clr       (err_clr),
    .bypass_o      (bypass_o),
    .mode_o        (mode_o),
    .busy_o        (busy_o),
    .frame_cnt_o   (frame_cnt_o),
    .err_timeout_o (err_timeout_o),
    .err_cfg_o     (err_cfg_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one frame starting from IDLE; flags any bypass/mode change.
  task automatic run_frame(
    input int         act,
    input int         lag,
    input int         tail,
    input int         send_at,
    input logic [1:0] smode
  );
    logic [1:0] b0;
    logic [1:0] m0;
    b0  = bypass_o;
    m0  = mode_o;
    chg = 1'b0;
    vs_i = 1'b1;
    tick();
    if (bypass_o !== b0 || mode_o !== m0) chg = 1'b1;
    for (int i = 0; i < act; i++) begin
      cfg_valid = (i == send_at);
      cfg_mode  = smode;
      if (i == lag) vs_mon = 1'b1;
      tick();
      if (bypass_o !== b0 || mode_o !== m0) chg = 1'b1;
    end
    cfg_valid = 1'b0;
    vs_i = 1'b0;
    tick();
    if (bypass_o !== b0 || mode_o !== m0) chg = 1'b1;
    for (int i = 0; i < tail; i++) begin
      tick();
      if (bypass_o !== b0 || mode_o !== m0) chg = 1'b1;
    end
    vs_mon = 1'b0;
    tick();
    if (bypass_o !== b0 || mode_o !== m0) chg = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; vs_i = 1'b1; vs_mon = 1'b0;
    cfg_valid = 1'b0; cfg_mode = 2'd0; err_clr = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (mode_o !== 2'd0) begin
      n_bad++; $display("FAIL rst_mode got %0d exp 0", mode_o);
    end
    n_cmp++;
    if (bypass_o !== 2'b11) begin
      n_bad++; $display("FAIL rst_byp got %b exp 11", bypass_o);
    end
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_ready got %b exp 1", cfg_ready);
    end
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_bad++; $display("FAIL rst_busy got %b exp 1", busy_o);
    end
    n_cmp++;
    if (frame_cnt_o !== 16'd0) begin
      n_bad++; $display("FAIL rst_fc got %0d exp 0", frame_cnt_o);
    end
    n_cmp++;
    if ({err_timeout_o, err_cfg_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_err got %b exp 00", {err_timeout_o, err_cfg_o});
    end
  endtask

  task automatic test_sync;
    rst = 1'b1;
    cfg_valid = 1'b1; cfg_mode = 2'd1;
    tick();
    cfg_valid = 1'b0;
    n_cmp++;
    if (cfg_ready !== 1'b0) begin
      n_bad++; $display("FAIL sync_pend got %b exp 0", cfg_ready);
    end
    for (int i = 0; i < 100; i++) begin
      tick();
      n_cmp++;
      if (busy_o !== 1'b1 || bypass_o !== 2'b11) begin
        n_bad++;
        $display("FAIL sync_hold[%0d] got busy %b byp %b exp 1 11",
                 i, busy_o, bypass_o);
      end
    end
    vs_i = 1'b0;
    tick();
    n_cmp++;
    if (busy_o !== 1'b0 || bypass_o !== 2'b11) begin
      n_bad++;
      $display("FAIL sync_idle got busy %b byp %b exp 0 11",
               busy_o, bypass_o);
    end
    tick();
    n_cmp++;
    if (bypass_o !== 2'b10 || mode_o !== 2'd1) begin
      n_bad++;
      $display("FAIL sync_apply got byp %b mode %0d exp 10 1",
               bypass_o, mode_o);
    end
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_bad++; $display("FAIL sync_ready got %b exp 1", cfg_ready);
    end
  endtask

  task automatic test_cfg_idle;
    cfg_valid = 1'b1; cfg_mode = 2'd2;
    tick();
    cfg_valid = 1'b0;
    n_cmp++;
    if (cfg_ready !== 1'b0 || bypass_o !== 2'b10) begin
      n_bad++;
      $display("FAIL idle_c1 got rdy %b byp %b exp 0 10",
               cfg_ready, bypass_o);
    end
    tick();
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_bad++; $display("FAIL idle_rdy got %b exp 1", cfg_ready);
    end
    n_cmp++;
    if (bypass_o !== 2'b00 || mode_o !== 2'd2) begin
      n_bad++;
      $display("FAIL idle_apply got byp %b mode %0d exp 00 2",
               bypass_o, mode_o);
    end
  endtask

  task automatic test_rsvd;
    cfg_valid = 1'b1; cfg_mode = 2'd3;
    tick();
    cfg_valid = 1'b0;
    n_cmp++;
    if (err_cfg_o !== 1'b1) begin
      n_bad++; $display("FAIL rsvd_err got %b exp 1", err_cfg_o);
    end
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_bad++; $display("FAIL rsvd_rdy got %b exp 1", cfg_ready);
    end
    repeat (2) tick();
    n_cmp++;
    if (mode_o !== 2'd2 || bypass_o !== 2'b00) begin
      n_bad++;
      $display("FAIL rsvd_mode got mode %0d byp %b exp 2 00",
               mode_o, bypass_o);
    end
    err_clr = 1'b1; cfg_valid = 1'b1; cfg_mode = 2'd3;
    tick();
    cfg_valid = 1'b0;
    n_cmp++;
    if (err_cfg_o !== 1'b1) begin
      n_bad++; $display("FAIL rsvd_setwins got %b exp 1", err_cfg_o);
    end
    tick();
    err_clr = 1'b0;
    n_cmp++;
    if (err_cfg_o !== 1'b0) begin
      n_bad++; $display("FAIL rsvd_clr got %b exp 0", err_cfg_o);
    end
  endtask

  task automatic test_mid_frame;
    run_frame(24, 4, 6, 2, 2'd1);
    if (STATS) exp_fc = exp_fc + 16'd1;
    n_cmp++;
    if (chg !== 1'b0) begin
      n_bad++; $display("FAIL mid_change got %b exp 0", chg);
    end
    n_cmp++;
    if (busy_o !== 1'b0 || bypass_o !== 2'b00 || cfg_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_end got busy %b byp %b rdy %b exp 0 00 0",
               busy_o, bypass_o, cfg_ready);
    end
    n_cmp++;
    if (frame_cnt_o !== exp_fc) begin
      n_bad++; $display("FAIL mid_fc got %0d exp %0d", frame_cnt_o, exp_fc);
    end
    tick();
    n_cmp++;
    if (bypass_o !== 2'b10 || mode_o !== 2'd1) begin
      n_bad++;
      $display("FAIL mid_apply got byp %b mode %0d exp 10 1",
               bypass_o, mode_o);
    end
  endtask

  task automatic test_back_to_back;
    cfg_valid = 1'b1; cfg_mode = 2'd0;
    tick();
    cfg_valid = 1'b0;
    run_frame(8, 2, 3, -1, 2'd0);
    if (STATS) exp_fc = exp_fc + 16'd1;
    n_cmp++;
    if (chg !== 1'b0) begin
      n_bad++; $display("FAIL coin_change got %b exp 0", chg);
    end
    n_cmp++;
    if (cfg_ready !== 1'b0 || mode_o !== 2'd1) begin
      n_bad++;
      $display("FAIL coin_pend got rdy %b mode %0d exp 0 1",
               cfg_ready, mode_o);
    end
    n_cmp++;
    if (frame_cnt_o !== exp_fc) begin
      n_bad++; $display("FAIL coin_fc got %0d exp %0d", frame_cnt_o, exp_fc);
    end
    tick();
    n_cmp++;
    if (bypass_o !== 2'b11 || mode_o !== 2'd0 || cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL coin_apply got byp %b mode %0d rdy %b exp 11 0 1",
               bypass_o, mode_o, cfg_ready);
    end
  endtask

  task automatic test_timeout;
    vs_mon = 1'b0;
    vs_i = 1'b1;
    repeat (4) tick();
    vs_i = 1'b0;
    tick();
    repeat (63) tick();
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_bad++; $display("FAIL wd_hold got busy %b exp 1", busy_o);
    end
    tick();
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_bad++; $display("FAIL wd_exit got busy %b exp 0", busy_o);
    end
    n_cmp++;
    if (err_timeout_o !== STATS) begin
      n_bad++; $display("FAIL wd_err got %b exp %b", err_timeout_o, STATS);
    end
    n_cmp++;
    if (frame_cnt_o !== exp_fc) begin
      n_bad++; $display("FAIL wd_fc got %0d exp %0d", frame_cnt_o, exp_fc);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++;
    if (err_timeout_o !== 1'b0) begin
      n_bad++; $display("FAIL wd_clr got %b exp 0", err_timeout_o);
    end
  endtask

  task automatic test_frames;
    for (int f = 0; f < 3; f++) begin
      run_frame(6, 1, 2, -1, 2'd0);
      if (STATS) exp_fc = exp_fc + 16'd1;
      tick();
    end
    n_cmp++;
    if (frame_cnt_o !== exp_fc) begin
      n_bad++; $display("FAIL frames_fc got %0d exp %0d", frame_cnt_o, exp_fc);
    end
  endtask

  task automatic test_reset_mid_frame;
    vs_i = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    exp_fc = '0;
    repeat (5) tick();
    n_cmp++;
    if (busy_o !== 1'b1 || mode_o !== 2'd0 || frame_cnt_o !== exp_fc) begin
      n_bad++;
      $display("FAIL rmf_sync got busy %b mode %0d fc %0d exp 1 0 0",
               busy_o, mode_o, frame_cnt_o);
    end
    vs_i = 1'b0;
    tick();
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_bad++; $display("FAIL rmf_idle got busy %b exp 0", busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_cfg_idle();
    test_rsvd();
    test_mid_frame();
    test_back_to_back();
    test_timeout();
    test_frames();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

endmodule
